// File: rtl/dmem_arbiter_r0_if.sv
// Requester and RAM-side bus of the data-memory arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface dmem_arbiter_r0_if #(
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_W    = 8
);
  logic                 p0_req;
  logic                 p0_wren;
  logic [ADDR_W-1:0]    p0_addr;
  logic [BIT_WIDTH-1:0] p0_wdata;
  logic [1:0]           p0_size;
  logic                 p0_signed;
  logic                 p0_ack;
  logic                 p0_err;
  logic [BIT_WIDTH-1:0] p0_rdata;

  logic                 p1_req;
  logic                 p1_wren;
  logic [ADDR_W-1:0]    p1_addr;
  logic [BIT_WIDTH-1:0] p1_wdata;
  logic [1:0]           p1_size;
  logic                 p1_signed;
  logic                 p1_ack;
  logic                 p1_err;
  logic [BIT_WIDTH-1:0] p1_rdata;

  logic [ADDR_W-1:0]    mem_addr;
  logic [BIT_WIDTH-1:0] mem_data;
  logic                 mem_wren;
  logic                 mem_isSigned;
  logic [1:0]           mem_dataSize;
  logic [BIT_WIDTH-1:0] mem_q;

  modport slave (
    input  p0_req, p0_wren, p0_addr,
    input  p0_wdata, p0_size, p0_signed,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_wren, p1_addr,
    input  p1_wdata, p1_size, p1_signed,
    output p1_ack, p1_err, p1_rdata,
    output mem_addr, mem_data, mem_wren,
    output mem_isSigned, mem_dataSize,
    input  mem_q
  );

  modport master (
    output p0_req, p0_wren, p0_addr,
    output p0_wdata, p0_size, p0_signed,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_wren, p1_addr,
    output p1_wdata, p1_size, p1_signed,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_addr, mem_data, mem_wren,
    input  mem_isSigned, mem_dataSize,
    output mem_q
  );
endinterface

// File: rtl/dmem_arbiter_r0.sv
// Two-port arbiter in front of the byte-lane data RAM.
// ARB_ROUND_ROBIN_EN: round-robin ties, else port 0 priority.
module dmem_arbiter_r0 #(
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_W    = 8
) (
  input logic              clk,
  input logic              rst,
  dmem_arbiter_r0_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DONE, ERR
  } state_t;

  state_t state, state_nx;

  logic [1:0]           req;
  logic                 winner;
  logic                 last_grant;
  logic                 grant_q;
  logic                 wren_q;
  logic                 misalign;
  logic                 grant;

  logic                 sel_wren;
  logic [ADDR_W-1:0]    sel_addr;
  logic [BIT_WIDTH-1:0] sel_wdata;
  logic [1:0]           sel_size;
  logic                 sel_signed;

  logic [ADDR_W-1:0]    mem_addr_q;
  logic [BIT_WIDTH-1:0] mem_data_q;
  logic                 mem_wren_q;
  logic                 mem_signed_q;
  logic [1:0]           mem_size_q;
  logic [BIT_WIDTH-1:0] p0_rdata_q;
  logic [BIT_WIDTH-1:0] p1_rdata_q;

  // Pick the winner and mux its request fields.
  always_comb begin
    req = {bus.p1_req, bus.p0_req};
`ifdef ARB_ROUND_ROBIN_EN
    if (req == 2'b11) winner = ~last_grant;
    else              winner = ~req[0];
`else
    // With no request the value is unused.
    winner = ~req[0] & (req[1] | last_grant);
`endif
    sel_wren   = winner ? bus.p1_wren   : bus.p0_wren;
    sel_addr   = winner ? bus.p1_addr   : bus.p0_addr;
    sel_wdata  = winner ? bus.p1_wdata  : bus.p0_wdata;
    sel_size   = winner ? bus.p1_size   : bus.p0_size;
    sel_signed = winner ? bus.p1_signed : bus.p0_signed;
    misalign = ((sel_size == 2'b01) & sel_addr[0])
             | (sel_size[1] & (sel_addr[1:0] != 2'b00));
    grant = (state == IDLE) & (|req);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (|req) state_nx = misalign ? ERR : ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = DONE;
      DONE:  state_nx = IDLE;
      ERR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // RAM-side registers, grant bookkeeping and load data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wren_q   <= 1'b0;
      mem_signed_q <= 1'b0;
      mem_size_q   <= '0;
      last_grant   <= 1'b1;
      grant_q      <= 1'b0;
      wren_q       <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      mem_wren_q <= 1'b0;
      if (grant) begin
        mem_addr_q   <= sel_addr;
        mem_data_q   <= sel_wdata;
        mem_signed_q <= sel_signed;
        mem_size_q   <= sel_size;
        mem_wren_q   <= sel_wren & ~misalign;
        wren_q       <= sel_wren;
        grant_q      <= winner;
        last_grant   <= winner;
      end
      if (state == WAIT && !wren_q) begin
        if (grant_q) p1_rdata_q <= bus.mem_q;
        else         p0_rdata_q <= bus.mem_q;
      end
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_wren     = mem_wren_q;
  assign bus.mem_isSigned = mem_signed_q;
  assign bus.mem_dataSize = mem_size_q;

  assign bus.p0_ack   = (state == DONE) & ~grant_q;
  assign bus.p1_ack   = (state == DONE) &  grant_q;
  assign bus.p0_err   = (state == ERR)  & ~grant_q;
  assign bus.p1_err   = (state == ERR)  &  grant_q;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter_r0.sv
// Self-checking bench for dmem_arbiter_r0 with a
// behavioural byte RAM and a byte-array reference model.
module tb_dmem_arbiter_r0;
  localparam int BW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_r0_if #(.BIT_WIDTH(BW), .ADDR_W(AW)) bus ();

  dmem_arbiter_r0 #(.BIT_WIDTH(BW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural RAM standing in for dataRAM_r0.
  logic [7:0]  ram [256];
  logic [31:0] ram_q = '0;
  int          wr_count = 0;
  int          wren_cycles = 0;
  assign bus.mem_q = ram_q;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  always @(posedge clk) begin
    logic [31:0] v;
    int n;
    n = nbytes(bus.mem_dataSize);
    if (bus.mem_wren) begin
      for (int i = 0; i < n; i++)
        ram[bus.mem_addr + 8'(i)] <= bus.mem_data[8*i +: 8];
      wr_count++;
    end
    v = '0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = ram[bus.mem_addr + 8'(i)];
    if (bus.mem_isSigned && n == 1) v[31:8]  = {24{v[7]}};
    if (bus.mem_isSigned && n == 2) v[31:16] = {16{v[15]}};
    ram_q <= v;
  end

  always @(negedge clk) if (bus.mem_wren === 1'b1) wren_cycles++;

  // Reference model: memory contents and last load result per port.
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdata [2];

  function automatic logic [31:0] ref_load(input logic [7:0] a,
                                           input logic [1:0] sz,
                                           input logic sg);
    longint v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[a + 8'(i)]) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++)
      ref_mem[a + 8'(i)] = d[8*i +: 8];
  endtask

  function automatic logic is_mis(input logic [7:0] a, input logic [1:0] sz);
    return (sz == 2'b01 && (a % 2) != 0) || (sz[1] && (a % 4) != 0);
  endfunction

  function automatic logic ack_of(input int p);
    return p ? bus.p1_ack : bus.p0_ack;
  endfunction
  function automatic logic err_of(input int p);
    return p ? bus.p1_err : bus.p0_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return p ? bus.p1_rdata : bus.p0_rdata;
  endfunction

  task automatic set_req(input int p, input logic r, input logic wr,
                         input logic [7:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg);
    if (p == 0) begin
      bus.p0_req = r; bus.p0_wren = wr; bus.p0_addr = a;
      bus.p0_wdata = d; bus.p0_size = sz; bus.p0_signed = sg;
    end else begin
      bus.p1_req = r; bus.p1_wren = wr; bus.p1_addr = a;
      bus.p1_wdata = d; bus.p1_size = sz; bus.p1_signed = sg;
    end
  endtask

  // Drive one access; report the cycle (1 = after the sampling
  // edge) on which ack / err was seen, or -1.
  task automatic access(input int p, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [1:0] sz,
                        input logic sg, output int n_ack, output int n_err,
                        output int other);
    @(posedge clk); #1;
    set_req(p, 1'b1, wr, a, d, sz, sg);
    n_ack = -1; n_err = -1; other = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ack_of(1 - p) || err_of(1 - p)) other++;
      if (ack_of(p)) n_ack = c;
      if (err_of(p)) n_err = c;
      if (n_ack > 0 || n_err > 0) break;
    end
    set_req(p, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_addr, bus.mem_data, bus.mem_wren,
         bus.mem_isSigned, bus.mem_dataSize} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got addr=%h data=%h wren=%b sg=%b sz=%b want 0",
               bus.mem_addr, bus.mem_data, bus.mem_wren,
               bus.mem_isSigned, bus.mem_dataSize);
    end
    checks++;
    if ({bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ackerr: got %b%b%b%b want 0000",
               bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err);
    end
    checks++;
    if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h want 0", bus.p0_rdata, bus.p1_rdata);
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    int na, ne, ot, w0;
    w0 = wr_count;
    access(0, 1'b1, 8'h10, 32'hDEADBEEF, 2'b10, 1'b0, na, ne, ot);
    ref_store(8'h10, 2'b10, 32'hDEADBEEF);
    checks++;
    if (na != 3 || ne != -1) begin
      errors++;
      $display("FAIL store_latency: ack at %0d err at %0d want ack 3", na, ne);
    end
    checks++;
    if (wr_count - w0 != 1) begin
      errors++;
      $display("FAIL store_writes: got %0d want 1", wr_count - w0);
    end
    access(0, 1'b0, 8'h10, 32'h0, 2'b10, 1'b0, na, ne, ot);
    exp_rdata[0] = ref_load(8'h10, 2'b10, 1'b0);
    checks++;
    if (na != 3 || bus.p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_word: ack %0d data %h want 3 deadbeef", na, bus.p0_rdata);
    end
  endtask

  task automatic test_subword;
    int na, ne, ot;
    access(0, 1'b0, 8'h13, 32'h0, 2'b00, 1'b1, na, ne, ot);
    exp_rdata[0] = ref_load(8'h13, 2'b00, 1'b1);
    checks++;
    if (na != 3 || bus.p0_rdata !== 32'hFFFFFFDE) begin
      errors++;
      $display("FAIL load_byte_s: ack %0d data %h want 3 ffffffde", na, bus.p0_rdata);
    end
    access(0, 1'b0, 8'h12, 32'h0, 2'b01, 1'b0, na, ne, ot);
    exp_rdata[0] = ref_load(8'h12, 2'b01, 1'b0);
    checks++;
    if (na != 3 || bus.p0_rdata !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL load_half_u: ack %0d data %h want 3 0000dead", na, bus.p0_rdata);
    end
  endtask

  task automatic test_misaligned;
    int na, ne, ot, wc;
    wc = wren_cycles;
    access(1, 1'b1, 8'h21, 32'hA5A5A5A5, 2'b10, 1'b0, na, ne, ot);
    checks++;
    if (ne != 1 || na != -1 || ot != 0) begin
      errors++;
      $display("FAIL mis_store_err: err %0d ack %0d other %0d want 1 -1 0", ne, na, ot);
    end
    checks++;
    if (wren_cycles != wc) begin
      errors++;
      $display("FAIL mis_store_wren: got %0d wren cycles want 0", wren_cycles - wc);
    end
    checks++;
    if (bus.p1_rdata !== exp_rdata[1]) begin
      errors++;
      $display("FAIL mis_store_rdata: got %h want %h", bus.p1_rdata, exp_rdata[1]);
    end
    access(0, 1'b0, 8'h20, 32'h0, 2'b10, 1'b0, na, ne, ot);
    exp_rdata[0] = ref_load(8'h20, 2'b10, 1'b0);
    checks++;
    if (na != 3 || bus.p0_rdata !== exp_rdata[0]) begin
      errors++;
      $display("FAIL mis_ram_intact: ack %0d data %h want 3 %h", na, bus.p0_rdata, exp_rdata[0]);
    end
    access(0, 1'b0, 8'h05, 32'h0, 2'b01, 1'b0, na, ne, ot);
    checks++;
    if (ne != 1 || na != -1 || bus.p0_rdata !== exp_rdata[0]) begin
      errors++;
      $display("FAIL mis_half_load: err %0d ack %0d data %h want 1 -1 %h",
               ne, na, bus.p0_rdata, exp_rdata[0]);
    end
  endtask

  task automatic test_random;
    int na, ne, ot, p, w0;
    logic wr, sg, mis;
    logic [7:0] a;
    logic [1:0] sz;
    logic [31:0] d;
    for (int t = 0; t < 40; t++) begin
      p  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(8'h80, 8'hFF));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      d  = $urandom;
      mis = is_mis(a, sz);
      w0 = wr_count;
      access(p, wr, a, d, sz, sg, na, ne, ot);
      if (!mis && wr) ref_store(a, sz, d);
      if (!mis && !wr) exp_rdata[p] = ref_load(a, sz, sg);
      checks++;
      if ((mis && (ne != 1 || na != -1)) || (!mis && (na != 3 || ne != -1))
          || ot != 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: p%0d a=%h sz=%b ack %0d err %0d other %0d",
                 t, p, a, sz, na, ne, ot);
      end
      checks++;
      if (rdata_of(p) !== exp_rdata[p]
          || wr_count - w0 != ((!mis && wr) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_data[%0d]: p%0d a=%h sz=%b got %h want %h writes %0d",
                 t, p, a, sz, rdata_of(p), exp_rdata[p], wr_count - w0);
      end
    end
  endtask

  task automatic test_contention;
    int got_p [$];
    int got_c [$];
    int both;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h10, 32'h0, 2'b10, 1'b0);
    set_req(1, 1'b1, 1'b0, 8'h20, 32'h0, 2'b10, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    both = 0;
    for (int c = 1; c <= 40 && got_p.size() < 6; c++) begin
      @(posedge clk); #1;
      if (bus.p0_ack && bus.p1_ack) both++;
      if (bus.p0_ack) begin got_p.push_back(0); got_c.push_back(c); end
      else if (bus.p1_ack) begin got_p.push_back(1); got_c.push_back(c); end
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    checks++;
    if (got_p.size() != 6 || both != 0) begin
      errors++;
      $display("FAIL cont_count: got %0d acks (%0d double) want 6", got_p.size(), both);
    end
    for (int i = 0; i < got_p.size(); i++) begin
      int ep, ec;
`ifdef ARB_ROUND_ROBIN_EN
      ep = i % 2;
`else
      ep = 0;
`endif
      ec = 3 + 4 * i;
      checks++;
      if (got_p[i] != ep || got_c[i] != ec) begin
        errors++;
        $display("FAIL cont_order[%0d]: port %0d cycle %0d want port %0d cycle %0d",
                 i, got_p[i], got_c[i], ep, ec);
      end
    end
    exp_rdata[0] = ref_load(8'h10, 2'b10, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    exp_rdata[1] = ref_load(8'h20, 2'b10, 1'b0);
`endif
    checks++;
    if (bus.p0_rdata !== exp_rdata[0] || bus.p1_rdata !== exp_rdata[1]) begin
      errors++;
      $display("FAIL cont_data: got %h %h want %h %h",
               bus.p0_rdata, bus.p1_rdata, exp_rdata[0], exp_rdata[1]);
    end
  endtask

  task automatic test_reset_abort;
    int na, ne, ot, w0, pulses;
    access(0, 1'b1, 8'h40, 32'hCAFEF00D, 2'b10, 1'b0, na, ne, ot);
    ref_store(8'h40, 2'b10, 32'hCAFEF00D);
    w0 = wr_count;
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b1, 8'h40, 32'h12345678, 2'b10, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.mem_wren !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue: mem_wren %b want 1", bus.mem_wren);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.p1_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_wren: mem_wren %b ack %b want 0 0", bus.mem_wren, bus.p1_ack);
    end
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      pulses += int'(bus.p0_ack | bus.p1_ack | bus.p0_err | bus.p1_err);
    end
    checks++;
    if (pulses != 0 || wr_count != w0) begin
      errors++;
      $display("FAIL abort_quiet: pulses %0d writes %0d want 0 0", pulses, wr_count - w0);
    end
    access(0, 1'b0, 8'h40, 32'h0, 2'b10, 1'b0, na, ne, ot);
    exp_rdata[0] = ref_load(8'h40, 2'b10, 1'b0);
    checks++;
    if (na != 3 || bus.p0_rdata !== exp_rdata[0]) begin
      errors++;
      $display("FAIL abort_prior: ack %0d data %h want 3 %h", na, bus.p0_rdata, exp_rdata[0]);
    end
  endtask

  task automatic test_back_to_back;
    int na, ne, ot, c1, c2;
    logic [31:0] v0, v1;
    v0 = $urandom;
    v1 = $urandom;
    access(0, 1'b1, 8'h60, v0, 2'b10, 1'b0, na, ne, ot);
    ref_store(8'h60, 2'b10, v0);
    access(0, 1'b1, 8'h64, v1, 2'b10, 1'b0, na, ne, ot);
    ref_store(8'h64, 2'b10, v1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 8'h60, 32'h0, 2'b10, 1'b0);
    c1 = -1; c2 = -1;
    for (int c = 1; c <= 20 && c2 < 0; c++) begin
      @(posedge clk); #1;
      if (bus.p0_ack) begin
        if (c1 < 0) begin
          c1 = c;
          checks++;
          if (bus.p0_rdata !== ref_load(8'h60, 2'b10, 1'b0)) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", bus.p0_rdata, v0);
          end
          bus.p0_addr = 8'h64;
        end else begin
          c2 = c;
        end
      end
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    exp_rdata[0] = ref_load(8'h64, 2'b10, 1'b0);
    checks++;
    if (c1 != 3 || c2 - c1 != 4 || bus.p0_rdata !== exp_rdata[0]) begin
      errors++;
      $display("FAIL b2b_second: acks %0d %0d data %h want 3 7 %h",
               c1, c2, bus.p0_rdata, exp_rdata[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_store_load();
    test_subword();
    test_misaligned();
    test_random();
    test_contention();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
